// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with burst lock in front of a single-port
// synchronous memory. Port 0 = instruction fetch, port 1 = load/store.
//
// Ports: clk, rst_n (async, active-low)
//   reqN/weN/lockN/addrN/wdataN : requester N command, held until gntN
//   gntN                        : accepted this cycle (combinational)
//   rvalidN/errN/rdataN         : registered read / error response
//   mem_addr/mem_rd_en/mem_wr_en/mem_wdata/mem_rdata : memory side
module mem_arbiter #(
  parameter int MEM_SIZE  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic        lock0,
  input  logic [15:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic        lock1,
  input  logic [15:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] CMAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] CONE = BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] cnt_inc;
  logic          g0, g1;
  logic          arb;
  logic          pick;
  logic          pick_lock;

  logic          pend_v;
  logic          pend_port;
  logic          pend_err;

  logic          any_g;
  logic          s_we;
  logic [15:0]   s_addr;
  logic [31:0]   s_wdata;
  logic          in_rng;

  assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + CONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    g0        = 1'b0;
    g1        = 1'b0;
    arb       = 1'b0;
    pick      = 1'b0;
    pick_lock = 1'b0;

    unique case (state_q)
      OWN0: begin
        if (req0) begin
          g0    = 1'b1;
          cnt_d = cnt_inc;
          if (!lock0 || cnt_inc == CMAX) begin
            state_d = IDLE;
            rr_d    = 1'b1;
            cnt_d   = '0;
          end
        end else begin
          // owner went quiet: hand over this very cycle
          state_d = IDLE;
          rr_d    = 1'b1;
          cnt_d   = '0;
          arb     = 1'b1;
        end
      end
      OWN1: begin
        if (req1) begin
          g1    = 1'b1;
          cnt_d = cnt_inc;
          if (!lock1 || cnt_inc == CMAX) begin
            state_d = IDLE;
            rr_d    = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          state_d = IDLE;
          rr_d    = 1'b0;
          cnt_d   = '0;
          arb     = 1'b1;
        end
      end
      IDLE: arb = 1'b1;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (arb && (req0 || req1)) begin
      if (req0 && req1) begin
        pick = rr_d;
        rr_d = ~rr_d;
      end else begin
        pick = req1;
      end
      g0        = ~pick;
      g1        = pick;
      pick_lock = pick ? lock1 : lock0;
      if (pick_lock && MAX_BURST > 1) begin
        state_d = pick ? OWN1 : OWN0;
        cnt_d   = CONE;
      end
    end
  end

  assign gnt0  = g0 & rst_n;
  assign gnt1  = g1 & rst_n;
  assign any_g = gnt0 | gnt1;

  assign s_we    = gnt1 ? we1    : we0;
  assign s_addr  = gnt1 ? addr1  : addr0;
  assign s_wdata = gnt1 ? wdata1 : wdata0;
  assign in_rng  = (s_addr >= 16'd1) &&
                   (s_addr <= 16'(MEM_SIZE));

  // out-of-range accesses are granted but never reach the memory
  assign mem_rd_en = any_g & in_rng & ~s_we;
  assign mem_wr_en = any_g & in_rng & s_we;
  assign mem_addr  = (mem_rd_en | mem_wr_en) ? s_addr : '0;
  assign mem_wdata = mem_wr_en ? s_wdata : '0;

  // one response tag in flight, matching the memory read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_port <= 1'b0;
      pend_err  <= 1'b0;
    end else begin
      pend_v    <= any_g & (~s_we | ~in_rng);
      pend_port <= gnt1;
      pend_err  <= ~in_rng;
    end
  end

  assign rvalid0 = pend_v & ~pend_port;
  assign rvalid1 = pend_v & pend_port;
  assign err0    = rvalid0 & pend_err;
  assign err1    = rvalid1 & pend_err;
  assign rdata0  = (rvalid0 & ~pend_err) ? mem_rdata : '0;
  assign rdata1  = (rvalid1 & ~pend_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small registered-read memory model.
// Covers reset, single read, contention, lock burst, range errors, RAW order.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, we0, lock0;
  logic        req1, we1, lock1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic        err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [15:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:3];

  int checks;
  int errors;

  mem_arbiter #(
    .MEM_SIZE (2),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .we0      (we0),
    .lock0    (lock0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .req1     (req1),
    .we1      (we1),
    .lock1    (lock1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .err0     (err0),
    .err1     (err1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .mem_addr (mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[1:0]] <= mem_wdata;
    mem_rdata <= mem_rd_en ? mem[mem_addr[1:0]] : '0;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] e0, e1;
  logic       g0s, g1s;
  int         k;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req0 = 1'b1; we0 = 1'b0; lock0 = 1'b0;
    addr0 = 16'd1; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
    addr1 = 16'd1; wdata1 = '0;

    // reset state, request held during reset
    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // preload mem[1] through port 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd1;
    wdata0 = 32'hDEADBEEF;
    #1;
    check("pre_gnt0", 32'(gnt0), 32'd1);
    check("pre_wr_en", 32'(mem_wr_en), 32'd1);
    check("pre_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    req0 = 1'b0; we0 = 1'b0;
    #1;
    check("pre_norv", 32'(rvalid0), 32'd0);

    // single read
    tick();
    req0 = 1'b1; addr0 = 16'd1;
    #1;
    check("rd_gnt0", 32'(gnt0), 32'd1);
    check("rd_en", 32'(mem_rd_en), 32'd1);
    check("rd_addr", 32'(mem_addr), 32'd1);
    tick();
    req0 = 1'b0;
    #1;
    check("rd_rv0", 32'(rvalid0), 32'd1);
    check("rd_data0", rdata0, 32'hDEADBEEF);
    check("rd_err0", 32'(err0), 32'd0);
    check("rd_rv1", 32'(rvalid1), 32'd0);
    check("rd_data1", rdata1, 32'd0);

    // contention without lock: 0,1,0,1
    tick();
    req0 = 1'b1; addr0 = 16'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ct_gnt0", 32'(gnt0), 32'((i % 2) == 0));
      check("ct_gnt1", 32'(gnt1), 32'((i % 2) == 1));
      if (i > 0) begin
        check("ct_rv0", 32'(rvalid0), 32'(((i - 1) % 2) == 0));
        check("ct_rv1", 32'(rvalid1), 32'(((i - 1) % 2) == 1));
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("ct_last_rv1", 32'(rvalid1), 32'd1);
    check("ct_last_d1", rdata1, 32'hDEADBEEF);

    // lock burst on port 1, port 0 waiting
    tick();
    e1 = 6'b101111;
    e0 = 6'b010000;
    k = 0;
    req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1;
    addr1 = 16'd1; wdata1 = 32'hA0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 16'd2;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) req0 = 1'b1;
      #1;
      check("bu_gnt1", 32'(gnt1), 32'(e1[c]));
      check("bu_gnt0", 32'(gnt0), 32'(e0[c]));
      if (c == 5) begin
        check("bu_rv0", 32'(rvalid0), 32'd1);
        check("bu_rd0", rdata0, 32'hA3);
      end
      g0s = gnt0;
      g1s = gnt1;
      tick();
      if (g0s) req0 = 1'b0;
      if (g1s) begin
        k++;
        addr1 = ((k % 2) == 0) ? 16'd1 : 16'd2;
        wdata1 = 32'hA0 + 32'(k);
      end
    end
    req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0;
    #1;
    check("bu_rel", 32'(gnt1), 32'd0);

    // out-of-range read then write
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd0;
    #1;
    check("or_gnt1", 32'(gnt1), 32'd1);
    check("or_rd_en", 32'(mem_rd_en), 32'd0);
    check("or_wr_en", 32'(mem_wr_en), 32'd0);
    tick();
    we1 = 1'b1; addr1 = 16'd3; wdata1 = 32'hFFFFFFFF;
    #1;
    check("or_rv1a", 32'(rvalid1), 32'd1);
    check("or_err1a", 32'(err1), 32'd1);
    check("or_d1a", rdata1, 32'd0);
    check("or_wgnt1", 32'(gnt1), 32'd1);
    check("or_wr_en2", 32'(mem_wr_en), 32'd0);
    tick();
    req1 = 1'b0; we1 = 1'b0;
    #1;
    check("or_rv1b", 32'(rvalid1), 32'd1);
    check("or_err1b", 32'(err1), 32'd1);

    // write then read same address
    tick();
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'd2;
    wdata1 = 32'h12345678;
    #1;
    check("raw_wr_en", 32'(mem_wr_en), 32'd1);
    tick();
    we1 = 1'b0;
    #1;
    check("raw_rd_en", 32'(mem_rd_en), 32'd1);
    check("raw_norv", 32'(rvalid1), 32'd0);
    tick();
    req1 = 1'b0;
    #1;
    check("raw_rv1", 32'(rvalid1), 32'd1);
    check("raw_err1", 32'(err1), 32'd0);
    check("raw_d1", rdata1, 32'h12345678);

    // reset while a read response is pending
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd1;
    #1;
    check("mr_gnt0", 32'(gnt0), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_rv0", 32'(rvalid0), 32'd0);
    check("mr_gnt0_off", 32'(gnt0), 32'd0);
    check("mr_rd_en", 32'(mem_rd_en), 32'd0);
    check("mr_addr", 32'(mem_addr), 32'd0);
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mr_post_rv0", 32'(rvalid0), 32'd0);
    check("mr_post_rv1", 32'(rvalid1), 32'd0);

    // round-robin restarts at port 0
    req0 = 1'b1; req1 = 1'b1; addr0 = 16'd1; addr1 = 16'd1;
    #1;
    check("rr_gnt0", 32'(gnt0), 32'd1);
    check("rr_gnt1", 32'(gnt1), 32'd0);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
